fifo_write_arbiter: RTL and testbench

//  Write-side controller of the async FIFO, clock_write domain. Shares the single FIFO write port between
//  two requesters (round-robin, valid/ready), drives RAM write enable/address/data, maintains the Gray

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_write_arbiter_if.sv | 28 ++
 rtl/rr_arb2.sv | 35 +++
 rtl/fifo_write_arbiter.sv | 85 ++++++++
 tb/tb_fifo_write_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing defaults and Gray-code helpers
// for the async FIFO write side.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH = 2 ** DEF_ADDR_WIDTH;

  function automatic logic [31:0] bin2gray(
    input logic [31:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(
    input logic [31:0] g
  );
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Two-requester valid/ready bundle feeding
// the FIFO write port.
interface fifo_write_arbiter_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [1:0]            req_valid;
  logic [DATA_WIDTH-1:0] req_data0;
  logic [DATA_WIDTH-1:0] req_data1;
  logic [1:0]            req_ready;

  modport master (
    output req_valid,
    output req_data0,
    output req_data1,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data0,
    input  req_data1,
    output req_ready
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the loser of
// a tie wins the next contested cycle.
module rr_arb2 (
  input  logic       clock_write,
  input  logic       write_reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic last_grant;

  // grant from requests and who won last
  always_comb begin
    grant = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // remember the winner of each transfer
  always_ff @(posedge clock_write) begin
    if (write_reset) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Write-side controller of the async FIFO:
// arbitration, RAM write, Gray pointer, flags.
module fifo_write_arbiter
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                  clock_write,
  input  logic                  write_reset,
  fifo_write_arbiter_if.slave   req,
  input  logic [ADDR_WIDTH:0]   sync_read_pointer,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [ADDR_WIDTH:0]   write_pointer,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   fill_level
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [PW-1:0] AF_LEVEL =
    PW'(DEPTH - AFULL_MARGIN);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rgray_full;
  logic [PW-1:0] fill_next;
  logic [1:0]    grant;
  logic          arb_en;
  logic          full_next;
  logic          afull_next;

  assign arb_en = ~full & ~write_reset;

  rr_arb2 u_arb (
    .clock_write (clock_write),
    .write_reset (write_reset),
    .req         (req.req_valid),
    .en          (arb_en),
    .grant       (grant)
  );

  assign req.req_ready = grant;
  assign mem_write_en = |(req.req_valid & grant);
  assign mem_write_addr = wbin[ADDR_WIDTH-1:0];
  assign mem_write_data = grant[1] ? req.req_data1
                                   : req.req_data0;

  // next pointer and flags; full compares against
  // the read pointer with its top two Gray bits flipped
  always_comb begin
    wbin_next  = wbin + PW'(mem_write_en);
    gray_next  = PW'(bin2gray(32'(wbin_next)));
    rbin       = PW'(gray2bin(32'(sync_read_pointer)));
    rgray_full = {~sync_read_pointer[ADDR_WIDTH -: 2],
                  sync_read_pointer[ADDR_WIDTH-2:0]};
    full_next  = (gray_next == rgray_full);
    fill_next  = wbin_next - rbin;
    afull_next = (fill_next >= AF_LEVEL);
  end

  // pointer and flag registers
  always_ff @(posedge clock_write) begin
    if (write_reset) begin
      wbin          <= '0;
      write_pointer <= '0;
      full          <= 1'b0;
      almost_full   <= 1'b0;
      fill_level    <= '0;
    end else begin
      wbin          <= wbin_next;
      write_pointer <= gray_next;
      full          <= full_next;
      almost_full   <= afull_next;
      fill_level    <= fill_next;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter:
// vector table plus multi-cycle sequences.
module tb_fifo_write_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rptr;
  logic       we;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic [7:0] wptr;
  logic       full;
  logic       afull;
  logic [7:0] fill;

  int total = 0;
  int passed = 0;

  fifo_write_arbiter_if #(.DATA_WIDTH(8)) bus ();

  fifo_write_arbiter #(
    .ADDR_WIDTH   (7),
    .DATA_WIDTH   (8),
    .AFULL_MARGIN (4)
  ) dut (
    .clock_write       (clk),
    .write_reset       (rst),
    .req               (bus),
    .sync_read_pointer (rptr),
    .mem_write_en      (we),
    .mem_write_addr    (addr),
    .mem_write_data    (wdata),
    .write_pointer     (wptr),
    .full              (full),
    .almost_full       (afull),
    .fill_level        (fill)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] v;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] ready;
    logic       we;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] wptr;
    logic [7:0] fill;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [7:0] gray8(
    input logic [7:0] b
  );
    return b ^ {1'b0, b[7:1]};
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s got=%0h expected=%0h",
                  name, act, exp);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 2'b00;
    rptr = 8'h00;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int bad_rdy;
    int bad_addr;
    int bad_ptr;
    int bad_full;

    rst = 1'b1;
    rptr = 8'h00;
    bus.req_valid = 2'b00;
    bus.req_data0 = 8'h00;
    bus.req_data1 = 8'h00;
    repeat (2) @(posedge clk);

    tbl[0]  = '{1, 2'b01, 8'h11, 8'h00,
                2'b00, 0, 7'd0, 8'h00, 8'h00, 8'd0};
    tbl[1]  = '{0, 2'b01, 8'h11, 8'h00,
                2'b01, 1, 7'd0, 8'h11, 8'h00, 8'd0};
    tbl[2]  = '{0, 2'b01, 8'h22, 8'h00,
                2'b01, 1, 7'd1, 8'h22, 8'h01, 8'd1};
    tbl[3]  = '{0, 2'b01, 8'h33, 8'h00,
                2'b01, 1, 7'd2, 8'h33, 8'h03, 8'd2};
    tbl[4]  = '{0, 2'b00, 8'h33, 8'h00,
                2'b00, 0, 7'd3, 8'h00, 8'h02, 8'd3};
    tbl[5]  = '{1, 2'b11, 8'hA0, 8'hB0,
                2'b00, 0, 7'd3, 8'h00, 8'h02, 8'd3};
    tbl[6]  = '{0, 2'b11, 8'hA0, 8'hB0,
                2'b01, 1, 7'd0, 8'hA0, 8'h00, 8'd0};
    tbl[7]  = '{0, 2'b11, 8'hA1, 8'hB0,
                2'b10, 1, 7'd1, 8'hB0, 8'h01, 8'd1};
    tbl[8]  = '{0, 2'b11, 8'hA1, 8'hB1,
                2'b01, 1, 7'd2, 8'hA1, 8'h03, 8'd2};
    tbl[9]  = '{0, 2'b11, 8'hA2, 8'hB1,
                2'b10, 1, 7'd3, 8'hB1, 8'h02, 8'd3};
    tbl[10] = '{0, 2'b11, 8'hA2, 8'hB2,
                2'b01, 1, 7'd4, 8'hA2, 8'h06, 8'd4};
    tbl[11] = '{0, 2'b11, 8'hA3, 8'hB2,
                2'b10, 1, 7'd5, 8'hB2, 8'h07, 8'd5};
    tbl[12] = '{0, 2'b00, 8'hA3, 8'hB2,
                2'b00, 0, 7'd6, 8'h00, 8'h05, 8'd6};

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      bus.req_valid = tbl[i].v;
      bus.req_data0 = tbl[i].d0;
      bus.req_data1 = tbl[i].d1;
      rptr = 8'h00;
      #1;
      chk($sformatf("v%0d_ready", i),
          bus.req_ready, tbl[i].ready);
      chk($sformatf("v%0d_we", i), we, tbl[i].we);
      chk($sformatf("v%0d_addr", i), addr, tbl[i].addr);
      if (tbl[i].we)
        chk($sformatf("v%0d_data", i), wdata, tbl[i].data);
      chk($sformatf("v%0d_wptr", i), wptr, tbl[i].wptr);
      chk($sformatf("v%0d_fill", i), fill, tbl[i].fill);
      chk($sformatf("v%0d_full", i), full, 0);
    end

    // fill to full with read pointer parked at 0
    reset_dut();
    bad_rdy = 0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = 2'b01;
      bus.req_data0 = 8'(i);
      #1;
      if (bus.req_ready !== 2'b01 || addr !== 7'(i)
          || full !== 1'b0)
        bad_rdy++;
      if (i == 123) chk("t3_afull_123", afull, 0);
      if (i == 124) chk("t3_afull_124", afull, 1);
    end
    chk("t3_accept_128", bad_rdy, 0);
    @(negedge clk);
    #1;
    chk("t3_full", full, 1);
    chk("t3_ready_blocked", bus.req_ready, 2'b00);
    chk("t3_we_blocked", we, 0);
    chk("t3_fill", fill, 128);
    chk("t3_afull", afull, 1);
    chk("t3_wptr", wptr, 8'hC0);
    @(negedge clk);
    #1;
    chk("t3_ready_hold", bus.req_ready, 2'b00);

    // one read frees exactly one slot
    @(negedge clk);
    rptr = gray8(8'd1);
    #1;
    chk("t4_still_full", full, 1);
    chk("t4_rejected", we, 0);
    @(negedge clk);
    #1;
    chk("t4_full_drop", full, 0);
    chk("t4_ready", bus.req_ready, 2'b01);
    chk("t4_addr", addr, 0);
    chk("t4_fill", fill, 127);
    @(negedge clk);
    #1;
    chk("t4_full_again", full, 1);
    chk("t4_ready_off", bus.req_ready, 2'b00);
    chk("t4_wptr", wptr, 8'hC1);
    chk("t4_addr_next", addr, 1);
    chk("t4_fill_full", fill, 128);

    // wrap with the read pointer tracking writes
    reset_dut();
    bad_rdy = 0;
    bad_addr = 0;
    bad_ptr = 0;
    bad_full = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = 2'b01;
      rptr = gray8(8'(i));
      #1;
      if (bus.req_ready !== 2'b01) bad_rdy++;
      if (addr !== 7'(i)) bad_addr++;
      if (wptr !== gray8(8'(i))) bad_ptr++;
      if (full !== 1'b0 || fill > 8'd1) bad_full++;
      if (i == 128) chk("t5_addr_wrap", addr, 0);
      if (i == 255) chk("t5_wptr_80", wptr, 8'h80);
      if (i == 256) chk("t5_wptr_00", wptr, 8'h00);
    end
    chk("t5_ready", bad_rdy, 0);
    chk("t5_addr", bad_addr, 0);
    chk("t5_wptr", bad_ptr, 0);
    chk("t5_no_false_full", bad_full, 0);

    // reset in the middle of a contested burst
    reset_dut();
    rptr = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    chk("t6_g0", bus.req_ready, 2'b01);
    @(negedge clk);
    #1;
    chk("t6_g1", bus.req_ready, 2'b10);
    @(negedge clk);
    #1;
    chk("t6_g2", bus.req_ready, 2'b01);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", bus.req_ready, 2'b00);
    chk("t6_rst_we", we, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_wptr", wptr, 0);
    chk("t6_full", full, 0);
    chk("t6_afull", afull, 0);
    chk("t6_fill", fill, 0);
    chk("t6_addr", addr, 0);
    chk("t6_first_grant", bus.req_ready, 2'b01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
